// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_size_e  - access size encoding carried on req_size (2'b11 is reserved)
//   lsu_state_e - LSU control FSM states
//   NUM_LANES   - byte lanes per data word
package lsu_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } lsu_size_e;

  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering for the LSU.
// Ports:
//   i_size     - access size (lsu_size_e encoding; anything else acts as word)
//   i_offset   - byte offset inside the word, already normalised by the caller
//   i_unsigned - zero-extend load data when set
//   i_wdata    - right-aligned store data
//   i_rdata    - raw read word from memory
//   o_be_c     - byte enables
//   o_wdata_c  - lane-replicated store data
//   o_rdata_c  - shifted, truncated and extended load data
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [1:0]           i_size,
  input  logic [1:0]           i_offset,
  input  logic                 i_unsigned,
  input  logic [DW-1:0]        i_wdata,
  input  logic [DW-1:0]        i_rdata,
  output logic [NUM_LANES-1:0] o_be_c,
  output logic [DW-1:0]        o_wdata_c,
  output logic [DW-1:0]        o_rdata_c
);

  logic [DW-1:0] w_shift;
  logic          w_sext;

  // Bring the addressed lane(s) down to bit 0.
  assign w_shift = i_rdata >> {i_offset, 3'b000};
  assign w_sext  = ~i_unsigned;

  // Per-size enables, store replication and load extension.
  always_comb begin
    o_be_c    = {NUM_LANES{1'b1}};
    o_wdata_c = i_wdata;
    o_rdata_c = w_shift;
    case (i_size)
      SZ_BYTE: begin
        o_be_c    = NUM_LANES'(1) << i_offset;
        o_wdata_c = {NUM_LANES{i_wdata[LANE_W-1:0]}};
        o_rdata_c = {{(DW-8){w_sext & w_shift[7]}}, w_shift[7:0]};
      end
      SZ_HALF: begin
        o_be_c    = {{2{i_offset[1]}}, {2{~i_offset[1]}}};
        o_wdata_c = {2{i_wdata[15:0]}};
        o_rdata_c = {{(DW-16){w_sext & w_shift[15]}}, w_shift[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit with a req/gnt/rvalid memory port.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned/reserved-size
// requests are rejected with rsp_err instead of being aligned down).
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   req_valid/req_ready            - pipeline request handshake
//   req_we/size/unsigned/addr/wdata - request fields
//   rsp_valid/rsp_rdata/rsp_err    - one-cycle response
//   busy                           - access in flight (state != IDLE)
//   mem_req/we/be/addr/wdata       - memory request, held until mem_gnt
//   mem_gnt/mem_rvalid/mem_rdata   - memory grant, completion and read data
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [AW-1:0]        req_addr,
  input  logic [DW-1:0]        req_wdata,
  output logic                 rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [NUM_LANES-1:0] mem_be,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [DW-1:0]        mem_rdata
);

  lsu_state_e r_state;
  lsu_state_e w_state_nxt;
  logic [1:0] r_size;
  logic [1:0] r_off;
  logic       r_we;
  logic       r_uns;

  logic [1:0] w_in_size;
  logic [1:0] w_in_off;
  logic       w_fault;
  logic       w_accept;
  logic [1:0] w_al_size;
  logic [1:0] w_al_off;
  logic       w_al_uns;
  logic [NUM_LANES-1:0] w_be;
  logic [DW-1:0]        w_wdata;
  logic [DW-1:0]        w_rdata;
  logic w_ready_nxt;
  logic w_busy_nxt;
  logic w_mem_req_nxt;
  logic w_rsp_valid_nxt;

  assign w_accept = (r_state == ST_IDLE) && req_valid;

  // Classify or normalise the incoming request's size and lane offset.
  always_comb begin
    w_in_size = req_size;
    w_in_off  = req_addr[1:0];
    w_fault   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    w_fault = (req_size == SZ_RSVD) ||
              ((req_size == SZ_HALF) && req_addr[0]) ||
              ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    if (req_size == SZ_RSVD) w_in_size = SZ_WORD;
    if (w_in_size == SZ_HALF)      w_in_off = {req_addr[1], 1'b0};
    else if (w_in_size == SZ_WORD) w_in_off = 2'b00;
`endif
  end

  // One aligner: fed from the live request while idle (to build the memory
  // request), from the registered request otherwise (to extract load data).
  assign w_al_size = (r_state == ST_IDLE) ? w_in_size    : r_size;
  assign w_al_off  = (r_state == ST_IDLE) ? w_in_off     : r_off;
  assign w_al_uns  = (r_state == ST_IDLE) ? req_unsigned : r_uns;

  lsu_align #(.DW(DW)) u_align (
    .i_size     (w_al_size),
    .i_offset   (w_al_off),
    .i_unsigned (w_al_uns),
    .i_wdata    (req_wdata),
    .i_rdata    (mem_rdata),
    .o_be_c     (w_be),
    .o_wdata_c  (w_wdata),
    .o_rdata_c  (w_rdata)
  );

  // Next state and next values of the state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (req_valid)  w_state_nxt = w_fault ? ST_RESP : ST_REQ;
      ST_REQ:  if (mem_gnt)    w_state_nxt = ST_WAIT;
      ST_WAIT: if (mem_rvalid) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_ready_nxt     = (w_state_nxt == ST_IDLE);
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
    w_mem_req_nxt   = (w_state_nxt == ST_REQ);
    w_rsp_valid_nxt = (w_state_nxt == ST_RESP);
  end

  // State, registered request and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_size    <= 2'b00;
      r_off     <= 2'b00;
      r_we      <= 1'b0;
      r_uns     <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      req_ready <= w_ready_nxt;
      busy      <= w_busy_nxt;
      mem_req   <= w_mem_req_nxt;
      rsp_valid <= w_rsp_valid_nxt;
      if (w_accept) begin
        r_size    <= w_in_size;
        r_off     <= w_in_off;
        r_we      <= req_we;
        r_uns     <= req_unsigned;
        rsp_rdata <= '0;
        // Memory-side fields stay frozen from here until the grant.
        if (!w_fault) begin
          mem_we    <= req_we;
          mem_be    <= w_be;
          mem_addr  <= {req_addr[AW-1:2], 2'b00};
          mem_wdata <= w_wdata;
        end
      end
      if ((r_state == ST_WAIT) && mem_rvalid) begin
        rsp_rdata <= r_we ? '0 : w_rdata;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Error flag describes the most recently accepted request.
  always_ff @(posedge clk) begin
    if (rst)           rsp_err <= 1'b0;
    else if (w_accept) rsp_err <= w_fault;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the execute/memory stage of the core. Accepts one load or store request at a time from the pipeline, performs byte-lane alignment, drives a request/grant/rvalid data-memory port, and returns a sign- or zero-extended load result. The result feeds the memory-data input of the 4:1 writeback-select mux; a busy indication stalls the pipeline while an access is in flight.

## Interface
- DW, 32, data width; only 32 is supported, and byte-lane logic assumes 4 lanes
- AW, 32, address width
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  zero-extend the load result when set
- req_addr  in  AW  byte address
- req_wdata  in  DW  store data, right-aligned
- rsp_valid  out  1  one-cycle pulse when the result is ready
- rsp_rdata  out  DW  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or reserved-size request; valid with rsp_valid
- busy  out  1  high from acceptance until rsp_valid inclusive
- mem_req  out  1  memory request; held until granted
- mem_we  out  1  memory write enable
- mem_be  out  4  byte enables
- mem_addr  out  AW  word-aligned address: req_addr with [1:0] forced to 0
- mem_wdata  out  DW  lane-replicated store data
- mem_gnt  in  1  memory accepted mem_req this cycle
- mem_rvalid  in  1  access complete; read data valid for loads, acknowledge for stores
- mem_rdata  in  DW  read word

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE
  - req_ready=1.
  - On req_valid, all request fields are registered.
  - Go to REQ; or to RESP with the error flag set when the request is faulty (see Configuration).
- REQ
  - mem_req=1, with all mem_* outputs driven from the registered request.
  - On mem_gnt, go to WAIT.
- WAIT
  - mem_req=0.
  - On mem_rvalid, capture the extracted data and go to RESP.
- RESP
  - rsp_valid=1 for exactly one cycle, then return to IDLE.
  - req_ready=0 in RESP; there is no back-to-back acceptance.
- Byte enables
  - Byte: be = 1<<addr[1:0].
  - Half: be = 0011 or 1100, selected by addr[1].
  - Word: be = 1111.
- Store data
  - Byte: replicated to all 4 lanes.
  - Half: replicated to both halves.
  - Word: passed through.
- Load data
  - mem_rdata is shifted right by 8*addr[1:0].
  - The result is truncated to size, then sign-extended (req_unsigned=0) or zero-extended (req_unsigned=1).
  - Word loads ignore req_unsigned.
- Stores
  - rsp_rdata=0.
  - The flow is still REQ→WAIT→RESP; mem_rvalid is the write acknowledge.
- mem_rvalid outside WAIT and mem_gnt outside REQ are ignored.

## Timing
- Reset values
  - State IDLE.
  - req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0; busy=0.
  - mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Reset mid-access abandons the transaction: mem_req drops the next cycle and no rsp_valid is produced.
- Minimum latency for a normal access:
  - accept at cycle N;
  - mem_req at N+1 (a grant can arrive in the same cycle);
  - mem_rvalid at N+2 at the earliest;
  - rsp_valid at N+3.
- Faulty request: accepted at N, rsp_valid=1 with rsp_err=1 at N+1, and no mem_req.
- mem_req and all mem_* outputs remain stable until mem_gnt.
- Grant and rvalid stalls of any length are tolerated.
- busy = (state != IDLE).

## Configuration
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0]=1, a word access with addr[1:0]≠0, or req_size=11 is faulty.
  - A faulty request issues no memory access and returns rsp_err=1 with rsp_rdata=0.
- Undefined:
  - rsp_err is tied 0.
  - A misaligned half is aligned down to addr[1]*2.
  - A misaligned word is aligned down to offset 0.
  - size 11 is treated as word.
  - The access always proceeds.

## Structure
- lsu_pkg holds:
  - the size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the FSM state enum;
  - the constant NUM_LANES=4.
- Sub-module lsu_align: purely combinational.
  - Inputs: size, offset, unsigned flag, wdata, rdata.
  - Outputs: be, replicated wdata, extended rdata.
  - lsu instantiates it once and registers its load output in WAIT.

## Test plan
- Load byte, signed:
  - Stimulus: addr=0x103, size=00, mem_rdata=0x80FF_0000, grant in the first REQ cycle, rvalid one cycle later.
  - Required: mem_be=1000, mem_addr=0x100, rsp_rdata=0xFFFF_FF80 at N+3.
- Load half, unsigned:
  - Stimulus: addr=0x202, mem_rdata=0xBEEF_1234.
  - Required: mem_be=1100, rsp_rdata=0x0000_BEEF.
- Store byte with grant stall:
  - Stimulus: wdata=0x0000_00A5, addr=0x11, grant after 3 cycles.
  - Required: mem_wdata=0xA5A5_A5A5 and mem_be=0010, both held stable for all 3 cycles; rsp_valid one cycle after rvalid; rsp_rdata=0.
- Misaligned word with LSU_MISALIGN_TRAP_EN:
  - Stimulus: addr=0x6.
  - Required: no mem_req; rsp_valid=1 and rsp_err=1 at N+1.
  - Same stimulus without the macro: mem_addr=0x4, mem_be=1111, rsp_err=0.
- Reset in WAIT:
  - Stimulus: rst asserted while in WAIT.
  - Required: next cycle IDLE, all outputs at reset values; a later mem_rvalid produces no rsp_valid.
- Back-to-back requests:
  - Stimulus: req_valid held high.
  - Required: req_ready=0 from N+1 through the RESP cycle; the second request is accepted the cycle after rsp_valid.
